// File: rtl/mem_bus_arbiter.sv
// Shares one Wishbone-style memory port between instruction fetch and load/store.
// MEM wins ties; bus cycles cut short by a flush are drained without an ack.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no cycle on the bus, grant possible (blocked while flush_i)
// S_IF_BUS  | IF read cycle on the bus, waiting for bus_ack_i
// S_MEM_BUS | MEM load/store cycle on the bus, waiting for bus_ack_i
// S_IF_DONE | if_ack_o pulse, no grant this cycle
// S_MEM_DONE| mem_ack_o pulse, no grant this cycle
// S_DRAIN   | flushed cycle still on the bus, waiting for bus_ack_i
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic [DATA_W-1:0]     if_rdata_o,
    output logic                  if_ack_o,
    output logic                  stallreq_if_o,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [DATA_W/8-1:0]   mem_sel_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     mem_wdata_i,
    output logic [DATA_W-1:0]     mem_rdata_o,
    output logic                  mem_ack_o,
    output logic                  stallreq_mem_o,
    output logic                  bus_cyc_o,
    output logic                  bus_stb_o,
    output logic                  bus_we_o,
    output logic [DATA_W/8-1:0]   bus_sel_o,
    output logic [ADDR_W-1:0]     bus_adr_o,
    output logic [DATA_W-1:0]     bus_dat_o,
    input  logic [DATA_W-1:0]     bus_dat_i,
    input  logic                  bus_ack_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_IF_BUS, S_MEM_BUS, S_IF_DONE, S_MEM_DONE, S_DRAIN
    } state_e;

    state_e state_q, state_d;

    logic                cyc_q;
    logic                we_q;
    logic [DATA_W/8-1:0] sel_q;
    logic [ADDR_W-1:0]   adr_q;
    logic [DATA_W-1:0]   dat_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   mem_rdata_q;

    logic grant_mem, grant_if, cap_if, cap_mem, end_cyc;

    always_comb begin
        state_d   = state_q;
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        cap_if    = 1'b0;
        cap_mem   = 1'b0;
        end_cyc   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!flush_i) begin
                    if (mem_req_i) begin
                        grant_mem = 1'b1;
                        state_d   = S_MEM_BUS;
                    end else if (if_req_i) begin
                        grant_if = 1'b1;
                        state_d  = S_IF_BUS;
                    end
                end
            end
            S_IF_BUS: begin
                if (bus_ack_i) begin
                    end_cyc = 1'b1;
                    if (flush_i) begin
                        state_d = S_IDLE;
                    end else begin
                        cap_if  = 1'b1;
                        state_d = S_IF_DONE;
                    end
                end else if (flush_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_MEM_BUS: begin
                if (bus_ack_i) begin
                    end_cyc = 1'b1;
                    if (flush_i) begin
                        state_d = S_IDLE;
                    end else begin
                        cap_mem = ~we_q;
                        state_d = S_MEM_DONE;
                    end
                end else if (flush_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_IF_DONE, S_MEM_DONE: state_d = S_IDLE;
            S_DRAIN: begin
                if (bus_ack_i) begin
                    end_cyc = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Address/sel/data hold after the cycle ends; only cyc/stb/we drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            sel_q <= '0;
            adr_q <= '0;
            dat_q <= '0;
        end else if (grant_mem) begin
            cyc_q <= 1'b1;
            we_q  <= mem_we_i;
            sel_q <= mem_sel_i;
            adr_q <= mem_addr_i;
            dat_q <= mem_wdata_i;
        end else if (grant_if) begin
            cyc_q <= 1'b1;
            we_q  <= 1'b0;
            sel_q <= '1;
            adr_q <= if_addr_i;
            dat_q <= '0;
        end else if (end_cyc) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            if (cap_if)  if_rdata_q  <= bus_dat_i;
            if (cap_mem) mem_rdata_q <= bus_dat_i;
        end
    end

    assign if_ack_o    = (state_q == S_IF_DONE);
    assign mem_ack_o   = (state_q == S_MEM_DONE);
    assign if_rdata_o  = if_rdata_q;
    assign mem_rdata_o = mem_rdata_q;

    // Gated by rst so the stall requests clear asynchronously with the bus.
    assign stallreq_if_o  = rst & if_req_i  & ~if_ack_o  & ~flush_i;
    assign stallreq_mem_o = rst & mem_req_i & ~mem_ack_o & ~flush_i;

    assign bus_cyc_o = cyc_q;
    assign bus_stb_o = cyc_q;
    assign bus_we_o  = we_q;
    assign bus_sel_o = sel_q;
    assign bus_adr_o = adr_q;
    assign bus_dat_o = dat_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model of the shared bus port.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        stallreq_if_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        stallreq_mem_o;
    logic        bus_cyc_o, bus_stb_o, bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_adr_o, bus_dat_o, bus_dat_i;
    logic        bus_ack_i;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
        .if_ack_o(if_ack_o), .stallreq_if_o(stallreq_if_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
        .mem_ack_o(mem_ack_o), .stallreq_mem_o(stallreq_mem_o),
        .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
        .bus_sel_o(bus_sel_o), .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o),
        .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the access currently owning the bus, plus pending ack.
    bit          m_busy, m_drain;
    int          m_ack_who;   // 0 none, 1 IF, 2 MEM
    int          m_who;
    bit          m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_dat, m_if_rd, m_mem_rd;

    int slave_wait, cyc_cnt;
    bit drop_if, drop_mem;
    int cnt_stall_if, cnt_stall_mem, cnt_if_ack, cnt_mem_ack;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void mdl_reset();
        m_busy = 0; m_drain = 0; m_ack_who = 0; m_who = 0; m_we = 0;
        m_sel = '0; m_adr = '0; m_dat = '0; m_if_rd = '0; m_mem_rd = '0;
    endfunction

    function automatic void clr_cnt();
        cnt_stall_if = 0; cnt_stall_mem = 0; cnt_if_ack = 0; cnt_mem_ack = 0;
    endfunction

    task automatic mdl_check();
        bit e_if_ack, e_mem_ack;
        if (!rst) mdl_reset();
        e_if_ack  = (m_ack_who == 1);
        e_mem_ack = (m_ack_who == 2);
        chk("bus_cyc",   bus_cyc_o,  m_busy);
        chk("bus_stb",   bus_stb_o,  m_busy);
        chk("bus_we",    bus_we_o,   m_busy & m_we);
        chk("bus_sel",   bus_sel_o,  m_sel);
        chk("bus_adr",   bus_adr_o,  m_adr);
        chk("bus_dat",   bus_dat_o,  m_dat);
        chk("if_ack",    if_ack_o,   e_if_ack);
        chk("mem_ack",   mem_ack_o,  e_mem_ack);
        chk("if_rdata",  if_rdata_o, m_if_rd);
        chk("mem_rdata", mem_rdata_o, m_mem_rd);
        chk("stall_if",  stallreq_if_o,  rst & if_req_i  & !e_if_ack  & !flush_i);
        chk("stall_mem", stallreq_mem_o, rst & mem_req_i & !e_mem_ack & !flush_i);
        cnt_stall_if  += int'(stallreq_if_o);
        cnt_stall_mem += int'(stallreq_mem_o);
        cnt_if_ack    += int'(if_ack_o);
        cnt_mem_ack   += int'(mem_ack_o);
    endtask

    function automatic void mdl_advance();
        if (!rst) return;
        if (m_ack_who != 0) begin
            m_ack_who = 0;
        end else if (m_busy) begin
            if (bus_ack_i) begin
                if (!m_drain && !flush_i) begin
                    if (m_who == 1) m_if_rd = bus_dat_i;
                    else if (!m_we) m_mem_rd = bus_dat_i;
                    m_ack_who = m_who;
                end
                m_busy = 0; m_drain = 0; m_we = 0;
            end else if (flush_i) begin
                m_drain = 1;
            end
        end else if (!flush_i) begin
            if (mem_req_i) begin
                m_busy = 1; m_who = 2; m_we = mem_we_i;
                m_sel = mem_sel_i; m_adr = mem_addr_i; m_dat = mem_wdata_i;
            end else if (if_req_i) begin
                m_busy = 1; m_who = 1; m_we = 0;
                m_sel = 4'hF; m_adr = if_addr_i; m_dat = '0;
            end
        end
    endfunction

    // One clock: check this cycle, advance model, then requester/slave reactions.
    task automatic step();
        @(negedge clk);
        mdl_check();
        mdl_advance();
        drop_if  = if_ack_o;
        drop_mem = mem_ack_o;
        @(posedge clk);
        #1;
        if (drop_if)  if_req_i  = 1'b0;
        if (drop_mem) mem_req_i = 1'b0;
        if (bus_cyc_o) cyc_cnt++;
        else           cyc_cnt = 0;
        bus_ack_i = bus_cyc_o && (cyc_cnt > slave_wait);
    endtask

    initial begin
        rst = 1'b0; flush_i = 0; if_req_i = 0; if_addr_i = 0;
        mem_req_i = 0; mem_we_i = 0; mem_sel_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
        bus_dat_i = 0; bus_ack_i = 0; slave_wait = 0; cyc_cnt = 0;
        mdl_reset(); clr_cnt();
        #3;
        chk("rst_cyc", bus_cyc_o, 0);
        chk("rst_adr", bus_adr_o, 0);
        chk("rst_if_rdata", if_rdata_o, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // IF only, zero-wait slave
        clr_cnt();
        if_req_i = 1; if_addr_i = 32'h100; bus_dat_i = 32'hDEADBEEF; slave_wait = 0;
        repeat (4) step();
        chk("if_only_rdata", if_rdata_o, 32'hDEADBEEF);
        chk("if_only_stall_cycles", cnt_stall_if, 2);
        chk("if_only_acks", cnt_if_ack, 1);

        // Simultaneous: MEM store first, then IF
        clr_cnt();
        if_req_i = 1; if_addr_i = 32'h200;
        mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h80; mem_wdata_i = 32'h12345678;
        mem_sel_i = 4'h3; bus_dat_i = 32'hCAFEF00D;
        repeat (7) step();
        chk("sim_stall_if_cycles", cnt_stall_if, 5);
        chk("sim_stall_mem_cycles", cnt_stall_mem, 2);
        chk("sim_mem_rdata_store", mem_rdata_o, 0);
        chk("sim_if_rdata", if_rdata_o, 32'hCAFEF00D);

        // MEM load with 3 wait states
        clr_cnt();
        mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h44; mem_sel_i = 4'hF;
        bus_dat_i = 32'hA5A50001; slave_wait = 3;
        repeat (7) step();
        chk("ws_stall_mem_cycles", cnt_stall_mem, 5);
        chk("ws_mem_rdata", mem_rdata_o, 32'hA5A50001);

        // Flush in cycle 2 of an IF bus cycle acked in cycle 4
        clr_cnt();
        if_req_i = 1; if_addr_i = 32'h300; bus_dat_i = 32'h11111111; slave_wait = 3;
        repeat (2) step();
        flush_i = 1;
        step();
        flush_i = 0; if_req_i = 0;
        repeat (4) step();
        chk("flush_if_acks", cnt_if_ack, 0);
        chk("flush_if_rdata", if_rdata_o, 32'hCAFEF00D);

        // Asynchronous reset in the middle of a MEM bus cycle
        mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h40; slave_wait = 5;
        step();
        #2 rst = 1'b0;
        #1;
        chk("arst_cyc", bus_cyc_o, 0);
        chk("arst_stb", bus_stb_o, 0);
        chk("arst_mem_ack", mem_ack_o, 0);
        chk("arst_if_ack", if_ack_o, 0);
        chk("arst_stall_mem", stallreq_mem_o, 0);
        chk("arst_stall_if", stallreq_if_o, 0);
        step();
        rst = 1'b1; slave_wait = 0; bus_dat_i = 32'h0BADF00D;
        clr_cnt();
        repeat (5) step();
        chk("arst_regrant_acks", cnt_mem_ack, 1);
        chk("arst_mem_rdata", mem_rdata_o, 32'h0BADF00D);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (!bus_cyc_o) slave_wait = $urandom_range(0, 3);
            flush_i = ($urandom_range(0, 11) == 0);
            if (!if_req_i && $urandom_range(0, 2) == 0) if_req_i = 1;
            else if (if_req_i && flush_i && $urandom_range(0, 1) == 0) if_req_i = 0;
            if (!mem_req_i && $urandom_range(0, 2) == 0) mem_req_i = 1;
            else if (mem_req_i && flush_i && $urandom_range(0, 1) == 0) mem_req_i = 0;
            if_addr_i   = $urandom;
            mem_addr_i  = $urandom;
            mem_we_i    = 1'($urandom_range(0, 1));
            mem_sel_i   = 4'($urandom_range(0, 15));
            mem_wdata_i = $urandom;
            bus_dat_i   = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
